// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider:
// channel state encoding, default sizes and the duty-cycle threshold.
package clkdiv_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    // div_clk is high once the count passes this value in a period of n.
    function automatic logic [31:0] hi_thresh(input logic [31:0] n);
        return (n - 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN state, period counter, active ratio
// and registered div_clk / tick / running enables.
module clk_div_chan
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] div,
    output logic             div_clk,
    output logic             tick,
    output logic             running
);

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_nact;
    logic [WIDTH-1:0] w_nact_nxt;
    logic             w_run;
    logic             w_last;
    logic             w_hi;
    logic             w_div_nz;
    logic             r_div_clk;
    logic             r_tick;
    logic             r_running;

    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == r_nact - WIDTH'(1));
    assign w_hi     = w_run && (32'(r_cnt) > hi_thresh(32'(r_nact)));
    assign w_div_nz = (div != '0);

    // Next-state, counter and ratio reload decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nact_nxt  = r_nact;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (en && w_div_nz) begin
                    w_nact_nxt  = div;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (sync || w_last) begin
                    w_cnt_nxt   = '0;
                    w_nact_nxt  = div;
                    w_state_nxt = w_div_nz ? ST_RUN : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + WIDTH'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and ratio registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_nact  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nact  <= w_nact_nxt;
        end
    end

    // Output enables registered from the pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_div_clk <= w_hi;
            r_tick    <= w_last;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    assign div_clk = r_div_clk;
    assign tick    = r_tick;
    assign running = r_running;

endmodule

// File: rtl/multi_clk_divider.sv
// NCH independent programmable divider channels sharing one
// clock, reset and realign strobe.
module multi_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic                 sync,
    input  logic [NCH*WIDTH-1:0] div,
    output logic [NCH-1:0]       div_clk,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       running
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en[g]),
            .sync   (sync),
            .div    (div[g*WIDTH +: WIDTH]),
            .div_clk(div_clk[g]),
            .tick   (tick[g]),
            .running(running[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider: directed table, corner sequences and
// random traffic against a period-position reference model.
module tb_multi_clk_divider;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] en;
    logic           sync;
    logic [NCH*W-1:0] div;
    logic [NCH-1:0] div_clk;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] running;

    int checks = 0;
    int errors = 0;

    multi_clk_divider #(
        .NCH  (NCH),
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .div    (div),
        .div_clk(div_clk),
        .tick   (tick),
        .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each channel is either stopped or at position k of a
    // period of length n; outputs describe the position before the edge.
    bit             m_run [NCH];
    int             m_k   [NCH];
    int             m_n   [NCH];
    logic [NCH-1:0] e_clk;
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_run;

    task automatic model_edge();
        int d;
        for (int c = 0; c < NCH; c++) begin
            d = int'(div[c*W +: W]);
            if (rst) begin
                m_run[c] = 0; m_k[c] = 0; m_n[c] = 0;
                e_clk[c] = 0; e_tick[c] = 0; e_run[c] = 0;
            end else begin
                e_tick[c] = m_run[c] && (m_k[c] == m_n[c] - 1);
                e_clk[c]  = m_run[c] && (m_k[c] >= m_n[c] - m_n[c] / 2);
                if (!m_run[c]) begin
                    if (en[c] && d != 0) begin
                        m_run[c] = 1; m_k[c] = 0; m_n[c] = d;
                    end
                end else if (!en[c]) begin
                    m_run[c] = 0; m_k[c] = 0;
                end else if (sync || m_k[c] == m_n[c] - 1) begin
                    m_k[c] = 0; m_n[c] = d; m_run[c] = (d != 0);
                end else begin
                    m_k[c] = m_k[c] + 1;
                end
                e_run[c] = m_run[c];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if ({div_clk, tick, running} !== {e_clk, e_tick, e_run}) begin
            errors++;
            $display("FAIL model t=%0t: div_clk=%b tick=%b running=%b required %b %b %b",
                     $time, div_clk, tick, running, e_clk, e_tick, e_run);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic set_div(input int ch, input int v);
        div[ch*W +: W] = W'(v);
    endtask

    task automatic wait_tick(input int ch, input int lim, output int n);
        n = -1;
        for (int j = 1; j <= lim; j++) begin
            step();
            if (tick[ch]) begin
                n = j;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; sync = 1'b0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en0;
        logic [7:0] div0;
        logic       clk_x;
        logic       tck_x;
        logic       run_x;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int n, n0, n1, n0b, hi, tk;
        rst = 1'b1; en = '0; sync = 1'b0; div = '0;

        tbl[0]  = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 8'd4, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'd4, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'd4, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'd4, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 8'd5, 1'b1, 1'b1, 1'b1};

        step();
        step();
        chk("reset div_clk", int'(div_clk), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset running", int'(running), 0);
        rst = 1'b0;

        // Directed ch0 sequence: enable at N=4, drop, re-enable at N=5.
        for (int i = 0; i < 17; i++) begin
            en[0] = tbl[i].en0;
            set_div(0, int'(tbl[i].div0));
            step();
            chk($sformatf("tbl%0d div_clk", i), int'(div_clk[0]), int'(tbl[i].clk_x));
            chk($sformatf("tbl%0d tick", i), int'(tick[0]), int'(tbl[i].tck_x));
            chk($sformatf("tbl%0d running", i), int'(running[0]), int'(tbl[i].run_x));
        end

        // N=1 on ch2, N=0 on ch3.
        do_reset();
        set_div(2, 1); set_div(3, 0); en = 4'b1100;
        step();
        hi = 0; tk = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            hi += int'(div_clk[2]);
            tk += int'(tick[2]);
        end
        chk("n1 ticks", tk, 6);
        chk("n1 div_clk high", hi, 0);
        chk("n0 running", int'(running[3]), 0);
        chk("n0 outputs", int'({div_clk[3], tick[3]}), 0);

        // Ratio change mid-period only affects the following period.
        do_reset();
        set_div(0, 4); en = 4'b0001;
        step();
        step();
        set_div(0, 6);
        wait_tick(0, 10, n);
        chk("ratio current period", n, 3);
        wait_tick(0, 10, n);
        chk("ratio next period", n, 6);

        // Sync realigns two out-of-phase channels.
        do_reset();
        set_div(0, 4); set_div(1, 6); en = 4'b0001;
        step();
        step();
        en = 4'b0011;
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        n0 = -1; n1 = -1; n0b = -1;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (tick[0] && n0 >= 0 && n0b < 0) n0b = j;
            if (tick[0] && n0 < 0) n0 = j;
            if (tick[1] && n1 < 0) n1 = j;
        end
        chk("sync ch0 tick", n0, 4);
        chk("sync ch1 tick", n1, 6);
        chk("sync ch0 second tick", n0b, 8);

        // Reset mid-period clears everything at once.
        set_div(0, 3); set_div(1, 5); set_div(2, 7); set_div(3, 2);
        en = 4'b1111;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst div_clk", int'(div_clk), 0);
        chk("midrst tick", int'(tick), 0);
        chk("midrst running", int'(running), 0);
        rst = 1'b0;
        step();
        chk("after rst tick", int'(tick), 0);

        // Maximum ratio.
        do_reset();
        div = '0; set_div(3, 255); en = 4'b1000;
        step();
        wait_tick(3, 300, n);
        chk("max first tick", n, 255);
        hi = 0; tk = 0;
        for (int j = 1; j <= 255; j++) begin
            step();
            hi += int'(div_clk[3]);
            tk += int'(tick[3]);
        end
        chk("max div_clk high", hi, 127);
        chk("max ticks per period", tk, 1);
        chk("max tick at period end", int'(tick[3]), 1);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < NCH; c++) set_div(c, int'($urandom_range(0, 9)));
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 15) == 0)
                en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0)
                set_div(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 9)));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; sync = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_clk_divider.md
# multi_clk_divider

Parametrised successor to the team's fixed-ratio clock divider. It provides NCH independent divider channels, each with a runtime-programmable divide ratio, a per-channel enable, a global phase-realign strobe, and a one-cycle period tick alongside the divided clock. Outputs are registered enable-style signals in the `clk` domain; they drive VGA/sprite/game-tick timing logic and must not be used as real clock nets.

## Interface
Parameters:
- NCH, 4, number of divider channels (1..16)
- WIDTH, 16, bit width of each divide ratio and counter (2..32)

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- en  input  NCH  per-channel enable; bit i controls channel i
- sync  input  1  global realign strobe; restarts every running channel at count 0
- div  input  NCH*WIDTH  divide ratios, packed; channel i uses div[i*WIDTH +: WIDTH]
- div_clk  output  NCH  divided clock per channel, registered
- tick  output  NCH  one-cycle pulse at the last cycle of each period, registered
- running  output  NCH  channel is in RUN state, registered

## Operation
- Each channel has state IDLE/RUN, counter cnt[WIDTH], and active ratio n_act[WIDTH].
- Reset: all channels enter IDLE. cnt=0, n_act=0, div_clk=0, tick=0, running=0.
- IDLE transitions:
  - If en[i]=1 and div_i≠0: load n_act←div_i, set cnt←0, go to RUN.
  - Otherwise stay in IDLE with cnt=0.
- RUN transitions, in priority order:
  - en[i]=0: go to IDLE, cnt←0.
  - sync=1: cnt←0, n_act←div_i. If div_i=0, go to IDLE.
  - cnt==n_act−1 (wrap): cnt←0, n_act←div_i. If div_i=0, go to IDLE.
  - Otherwise: cnt←cnt+1.
- Ratio changes on `div` take effect only at a wrap, a sync, or IDLE→RUN. A period already in progress is never shortened or stretched.
- Registered outputs are computed from the pre-edge state:
  - tick ← RUN && cnt==n_act−1
  - div_clk ← RUN && cnt > (n_act−1)>>1
  - running ← next state == RUN
- Duty cycle: high for floor(N/2) cycles, low for ceil(N/2) cycles. N=4 gives 2 high / 2 low; N=5 gives 2 high / 3 low.
- N=1: tick is high every cycle and div_clk stays 0.
- Comparisons use WIDTH-bit unsigned arithmetic. N=2^WIDTH−1 is the maximum ratio, and no overflow is possible.

## Timing
- en[i] sampled high at edge E: running=1 after E. The first div_clk rise is registered at edge E+floor((N−1)/2)+2. The first tick is registered at edge E+N.
- In steady state, tick has period N and is coincident with the last high cycle of div_clk for N≥2.
- en[i] sampled low at edge E: running, div_clk and tick are 0 after E+1. No partial-period completion.
- sync sampled at edge E: all running channels have cnt=0 after E. Their next ticks are registered at E+N_i.
- sync and a wrap in the same cycle: the result is identical to a wrap (cnt←0, reload).
- rst overrides en, sync and div in the same cycle. Reset mid-period leaves no residual tick.

## Structure
- Shared package `clkdiv_pkg`:
  - state encoding constants ST_IDLE/ST_RUN
  - the default WIDTH and NCH
  - a function returning the high-threshold (n−1)>>1
- Sub-module `clk_div_chan`: one channel containing the state, cnt, n_act and the three output registers, with ports clk, rst, en, sync, div[WIDTH], div_clk, tick, running.
- Top-level `multi_clk_divider` instantiates NCH `clk_div_chan` channels via generate and slices `div`. It contains no other logic.

## Test plan
- Reset, NCH=4, WIDTH=8; ch0 div=4, en rises at edge 10 → div_clk high at edges 13–14, low at 15–16; tick at edges 14, 18, 22, …; running=1 from edge 10.
- ch1 div=5 → 2-high/3-low pattern with tick period 5. ch2 div=1 → tick every cycle, div_clk constantly 0. ch3 div=0 with en=1 → stays IDLE with all outputs 0.
- ch0 running at div=4, change div to 6 at cnt=1 → current period still ends with a tick 4 cycles after its start; the following period is 6 cycles.
- ch0 div=4 and ch1 div=6 running out of phase; pulse sync for one cycle at edge E → both ticks land at E+4 and E+6, then continue at their own periods.
- Deassert en mid-period → outputs 0 one edge later; reassert → fresh period from cnt=0 with first tick N edges later. Assert rst mid-period → all outputs 0 after the reset edge.
- div=255 with WIDTH=8 → tick period 255, div_clk high for 127 cycles, no wrap glitch.
